// File: rtl/calc_seg_scan_if.sv
// Display-side bus of the calculator scan block: core value/dot in, panel pins and busy out.
interface calc_seg_scan_if;
    logic [6:0] result;
    logic       dot;
    logic [0:6] seg;
    logic       dp;
    logic [0:3] en;
    logic       busy;

    modport master (output result, dot, input seg, dp, en, busy);
    modport slave  (input result, dot, output seg, dp, en, busy);
endinterface

// File: rtl/calc_seg_scan.sv
// Binary-to-BCD (double dabble) plus 4-digit common-anode seven-segment scanner.
// Define CALC_SCAN_BLANK_EN to blank leading zeros instead of showing them.
module calc_seg_scan #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic            clk,
    input  logic            rst_n,
    calc_seg_scan_if.slave  bus
);
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [0:6] BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t      state_q, state_d;
    logic [6:0]  shown_q, shown_d;
    logic [6:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d, bcd_adj;
    logic [2:0]  it_q, it_d;
    logic [3:0]  d_h_q, d_h_d, d_t_q, d_t_d, d_u_q, d_u_d;
    logic        dot_q;
    logic [CW-1:0] ref_q;
    logic [1:0]  idx_q;
    logic [0:6]  seg_q, seg_d;
    logic [0:3]  en_q;
    logic        dp_q;

    function automatic logic [0:6] seg_of(input logic [3:0] d);
        case (d)
            4'd0: seg_of = 7'b0000001;
            4'd1: seg_of = 7'b1001111;
            4'd2: seg_of = 7'b0010010;
            4'd3: seg_of = 7'b0000110;
            4'd4: seg_of = 7'b1001100;
            4'd5: seg_of = 7'b0100100;
            4'd6: seg_of = 7'b0100000;
            4'd7: seg_of = 7'b0001111;
            4'd8: seg_of = 7'b0000000;
            4'd9: seg_of = 7'b0000100;
            default: seg_of = BLANK;
        endcase
    endfunction

    // Nibbles are always <= 9 here, so +3 never carries into the next nibble.
    always_comb begin
        bcd_adj = bcd_q;
        for (int n = 0; n < 3; n++)
            if (bcd_q[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
    end

    always_comb begin
        state_d = state_q;
        shown_d = shown_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        it_d    = it_q;
        d_h_d   = d_h_q;
        d_t_d   = d_t_q;
        d_u_d   = d_u_q;
        case (state_q)
            IDLE: if (bus.result != shown_q) begin
                bin_d   = bus.result;
                shown_d = bus.result;
                bcd_d   = '0;
                it_d    = '0;
                state_d = CONV;
            end
            CONV: begin
                bcd_d = {bcd_adj[10:0], bin_q[6]};
                bin_d = {bin_q[5:0], 1'b0};
                it_d  = it_q + 3'd1;
                if (it_q == 3'd6) state_d = LOAD;
            end
            LOAD: begin
                d_h_d   = bcd_q[11:8];
                d_t_d   = bcd_q[7:4];
                d_u_d   = bcd_q[3:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shown_q <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            it_q    <= '0;
            d_h_q   <= '0;
            d_t_q   <= '0;
            d_u_q   <= '0;
            dot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shown_q <= shown_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            it_q    <= it_d;
            d_h_q   <= d_h_d;
            d_t_q   <= d_t_d;
            d_u_q   <= d_u_d;
            dot_q   <= bus.dot;
        end
    end

    always_comb begin
        seg_d = BLANK;
        case (idx_q)
`ifdef CALC_SCAN_BLANK_EN
            2'd0: seg_d = BLANK;
            2'd1: seg_d = (d_h_q == 4'd0) ? BLANK : seg_of(d_h_q);
            2'd2: seg_d = (d_h_q == 4'd0 && d_t_q == 4'd0) ? BLANK : seg_of(d_t_q);
`else
            2'd0: seg_d = seg_of(4'd0);
            2'd1: seg_d = seg_of(d_h_q);
            2'd2: seg_d = seg_of(d_t_q);
`endif
            default: seg_d = seg_of(d_u_q);
        endcase
    end

    // Pins load only on the wrap edge, so seg/en/dp always change as one set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q <= '0;
            idx_q <= '0;
            seg_q <= BLANK;
            en_q  <= 4'b1111;
            dp_q  <= 1'b1;
        end else if (ref_q == CW'(REFRESH_DIV - 1)) begin
            ref_q <= '0;
            idx_q <= idx_q + 2'd1;
            seg_q <= seg_d;
            en_q  <= ~(4'b1000 >> idx_q);
            dp_q  <= !(idx_q == 2'd3 && dot_q);
        end else begin
            ref_q <= ref_q + CW'(1);
        end
    end

    assign bus.seg  = seg_q;
    assign bus.en   = en_q;
    assign bus.dp   = dp_q;
    assign bus.busy = (state_q != IDLE);
endmodule

// File: tb/tb_calc_seg_scan.sv
// Randomised self-checking bench for calc_seg_scan against a decimal-digit display model.
module tb_calc_seg_scan;
    localparam int RD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    calc_seg_scan_if bus();

    calc_seg_scan #(.REFRESH_DIV(RD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    int shown_m = 0;
    logic [0:6] obs_seg [4];
    logic       obs_dp  [4];
    bit         obs_bad;

    function automatic logic [0:6] digit_pat(input int d);
        case (d)
            0: digit_pat = 7'b0000001;  1: digit_pat = 7'b1001111;
            2: digit_pat = 7'b0010010;  3: digit_pat = 7'b0000110;
            4: digit_pat = 7'b1001100;  5: digit_pat = 7'b0100100;
            6: digit_pat = 7'b0100000;  7: digit_pat = 7'b0001111;
            8: digit_pat = 7'b0000000;  9: digit_pat = 7'b0000100;
            default: digit_pat = 7'b1111111;
        endcase
    endfunction

    // Expected pattern of display position pos (0 = leftmost) for value v.
    function automatic logic [0:6] exp_seg(input int v, input int pos);
        int dig [4];
        dig[0] = 0; dig[1] = v / 100; dig[2] = (v / 10) % 10; dig[3] = v % 10;
`ifdef CALC_SCAN_BLANK_EN
        if (pos == 0) return 7'b1111111;
        if (pos == 1 && dig[1] == 0) return 7'b1111111;
        if (pos == 2 && dig[1] == 0 && dig[2] == 0) return 7'b1111111;
`endif
        return digit_pat(dig[pos]);
    endfunction

    // Drives a new value and returns how many sampled cycles busy was high.
    task automatic do_convert(input int v, output int hi);
        bit seen = 0;
        hi = 0;
        @(negedge clk);
        bus.result = 7'(v);
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus.busy) begin hi++; seen = 1; end
            else if (seen) break;
        end
        shown_m = v;
    endtask

    // Lets every slot refresh, then records one full scan by digit position.
    task automatic sweep;
        obs_bad = 0;
        for (int k = 0; k < 4; k++) begin obs_seg[k] = 'x; obs_dp[k] = 1'bx; end
        repeat (4 * RD) @(negedge clk);
        for (int n = 0; n < 4 * RD; n++) begin
            @(negedge clk);
            case (bus.en)
                4'b0111: begin obs_seg[0] = bus.seg; obs_dp[0] = bus.dp; end
                4'b1011: begin obs_seg[1] = bus.seg; obs_dp[1] = bus.dp; end
                4'b1101: begin obs_seg[2] = bus.seg; obs_dp[2] = bus.dp; end
                4'b1110: begin obs_seg[3] = bus.seg; obs_dp[3] = bus.dp; end
                default: obs_bad = 1;
            endcase
        end
    endtask

    task automatic test_reset;
        bus.result = '0; bus.dot = 1'b0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tot++; if (bus.seg !== 7'b1111111) $display("FAIL reset_seg got %b want 1111111", bus.seg); else n_pass++;
        n_tot++; if (bus.dp !== 1'b1) $display("FAIL reset_dp got %b want 1", bus.dp); else n_pass++;
        n_tot++; if (bus.en !== 4'b1111) $display("FAIL reset_en got %b want 1111", bus.en); else n_pass++;
        n_tot++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
        rst_n = 1'b1;
        repeat (RD - 1) @(negedge clk);
        n_tot++; if (bus.en !== 4'b1111) $display("FAIL pre_wrap_en got %b want 1111", bus.en); else n_pass++;
        @(negedge clk);
        n_tot++; if (bus.en !== 4'b0111) $display("FAIL first_wrap_en got %b want 0111", bus.en); else n_pass++;
        shown_m = 0;
    endtask

    task automatic test_values;
        int vals [$];
        int hi;
        vals = '{42, 127, 5, 0, 100, 99, 10};
        for (int i = 0; i < 6; i++) vals.push_back(int'($urandom_range(1, 127)));
        foreach (vals[i]) begin
            if (vals[i] == shown_m) continue;
            do_convert(vals[i], hi);
            n_tot++; if (hi != 8) $display("FAIL busy_len v=%0d got %0d want 8", vals[i], hi); else n_pass++;
            sweep();
            n_tot++; if (obs_bad) $display("FAIL en_onehot v=%0d got bad en want one low bit", vals[i]); else n_pass++;
            for (int p = 0; p < 4; p++) begin
                n_tot++;
                if (obs_seg[p] !== exp_seg(vals[i], p))
                    $display("FAIL digit v=%0d pos=%0d got %b want %b", vals[i], p, obs_seg[p], exp_seg(vals[i], p));
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back;
        int hi, cyc, fall1, fall2, rise;
        bit prev;
        if (shown_m == 42) do_convert(1, hi);
        @(negedge clk); bus.result = 7'd42;
        repeat (3) @(posedge clk);
        @(negedge clk); bus.result = 7'd100;
        cyc = 0; fall1 = -1; fall2 = -1; rise = -1; prev = 1;
        while (cyc < 40 && fall2 < 0) begin
            @(negedge clk); cyc++;
            if (prev && !bus.busy) begin if (fall1 < 0) fall1 = cyc; else fall2 = cyc; end
            if (!prev && bus.busy && rise < 0) rise = cyc;
            prev = bus.busy;
        end
        shown_m = 100;
        n_tot++; if (fall1 != 6) $display("FAIL b2b_first_done got %0d want 6", fall1); else n_pass++;
        n_tot++; if (rise != 7) $display("FAIL b2b_restart got %0d want 7", rise); else n_pass++;
        n_tot++; if (fall2 != 15) $display("FAIL b2b_second_done got %0d want 15", fall2); else n_pass++;
        sweep();
        for (int p = 1; p < 4; p++) begin
            n_tot++;
            if (obs_seg[p] !== exp_seg(100, p)) $display("FAIL b2b_digit pos=%0d got %b want %b", p, obs_seg[p], exp_seg(100, p));
            else n_pass++;
        end
    endtask

    task automatic test_dot;
        for (int d = 1; d >= 0; d--) begin
            @(negedge clk); bus.dot = 1'(d);
            sweep();
            for (int p = 0; p < 4; p++) begin
                n_tot++;
                if (obs_dp[p] !== ((p == 3 && d == 1) ? 1'b0 : 1'b1))
                    $display("FAIL dp dot=%0d pos=%0d got %b want %b", d, p, obs_dp[p], (p == 3 && d == 1) ? 1'b0 : 1'b1);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid;
        int hi;
        @(negedge clk); bus.result = (shown_m == 77) ? 7'd78 : 7'd77;
        repeat (4) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        n_tot++; if (bus.busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", bus.busy); else n_pass++;
        n_tot++; if (bus.seg !== 7'b1111111) $display("FAIL mid_rst_seg got %b want 1111111", bus.seg); else n_pass++;
        n_tot++; if (bus.en !== 4'b1111) $display("FAIL mid_rst_en got %b want 1111", bus.en); else n_pass++;
        n_tot++; if (bus.dp !== 1'b1) $display("FAIL mid_rst_dp got %b want 1", bus.dp); else n_pass++;
        bus.result = '0;
        @(negedge clk); rst_n = 1'b1;
        shown_m = 0;
        do_convert(5, hi);
        n_tot++; if (hi != 8) $display("FAIL post_rst_busy got %0d want 8", hi); else n_pass++;
        sweep();
        for (int p = 0; p < 4; p++) begin
            n_tot++;
            if (obs_seg[p] !== exp_seg(5, p)) $display("FAIL post_rst_digit pos=%0d got %b want %b", p, obs_seg[p], exp_seg(5, p));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_values();
        test_back_to_back();
        test_dot();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
